// File: rtl/cp0_fwd_pipe_pkg.sv
// Shared CP0 forwarding definitions: default widths, CP0 register addresses and entry layout.
package cp0_fwd_pipe_pkg;

  localparam int unsigned CP0_DATA_W = 32;
  localparam int unsigned CP0_ADDR_W = 5;

  localparam logic [CP0_ADDR_W-1:0] CP0_STATUS = 5'd12;
  localparam logic [CP0_ADDR_W-1:0] CP0_CAUSE  = 5'd13;
  localparam logic [CP0_ADDR_W-1:0] CP0_EPC    = 5'd14;

  // Shadow entry layout at default widths; the pipe keeps each field in its own vector.
  typedef struct packed {
    logic                  vld;
    logic [CP0_ADDR_W-1:0] addr;
    logic [CP0_DATA_W-1:0] data;
    logic                  dok;
  } cp0_entry_t;

endpackage

// File: rtl/cp0_fwd_lookup.sv
// Priority search of one CP0 address over the shadow stages, youngest (stage 0) first.
module cp0_fwd_lookup #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LATE_STAGE = 1
) (
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [DEPTH-1:0]              vld_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  addr_vec_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  data_vec_i,
  input  logic [DEPTH-1:0]              dok_i,
  input  logic                          late_en_i,
  input  logic [DATA_W-1:0]             late_data_i,
  output logic                          hit_o,
  output logic                          pending_o,
  output logic [DATA_W-1:0]             data_o
);

  // Walk oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    hit_o     = 1'b0;
    pending_o = 1'b0;
    data_o    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (vld_i[k] && (addr_vec_i[k] == addr_i)) begin
        hit_o = 1'b1;
        if (dok_i[k]) begin
          pending_o = 1'b0;
          data_o    = data_vec_i[k];
        end else if ((k == LATE_STAGE) && late_en_i) begin
          pending_o = 1'b0;
          data_o    = late_data_i;
        end else begin
          pending_o = 1'b1;
          data_o    = '0;
        end
      end
    end
  end

endmodule

// File: rtl/cp0_fwd_pipe.sv
// CP0 write-tracking shadow pipeline with youngest-first read/EPC forwarding and oldest-entry commit.
module cp0_fwd_pipe
  import cp0_fwd_pipe_pkg::*;
#(
  parameter int unsigned      DATA_W     = CP0_DATA_W,
  parameter int unsigned      ADDR_W     = CP0_ADDR_W,
  parameter int unsigned      DEPTH      = 3,
  parameter int unsigned      NUM_RD     = 2,
  parameter int unsigned      LATE_STAGE = 1,
  parameter logic [ADDR_W-1:0] EPC_ADDR  = ADDR_W'(CP0_EPC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic [DATA_W-1:0]        iss_data_i,
  input  logic                     iss_dok_i,
  input  logic                     late_en_i,
  input  logic [DATA_W-1:0]        late_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD*DATA_W-1:0] rd_arr_i,
  input  logic [DATA_W-1:0]        epc_arr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_stall_o,
  output logic [DATA_W-1:0]        epc_o,
  output logic                     cp_we_o,
  output logic [ADDR_W-1:0]        cp_waddr_o,
  output logic [DATA_W-1:0]        cp_wdata_o
);

  logic [DEPTH-1:0]             vld_q, vld_d, dok_q, dok_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic                         late_fill;

  assign late_fill = late_en_i & vld_q[LATE_STAGE] & ~dok_q[LATE_STAGE];

  // Fill and flush act on current occupants first, so a filled entry carries its data when it moves
  // and a flushed entry cannot slip into the commit stage.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    dok_d  = dok_q;
    if (late_fill) begin
      dok_d[LATE_STAGE]  = 1'b1;
      data_d[LATE_STAGE] = late_data_i;
    end
    if (flush_i) begin
      vld_d[DEPTH-2:0] = '0;
    end
    if (!stall_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        vld_d[k]  = vld_d[k-1];
        addr_d[k] = addr_d[k-1];
        data_d[k] = data_d[k-1];
        dok_d[k]  = dok_d[k-1];
      end
      vld_d[0]  = iss_en_i & ~flush_i;
      addr_d[0] = iss_addr_i;
      data_d[0] = iss_data_i;
      dok_d[0]  = iss_dok_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      dok_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
      dok_q  <= dok_d;
    end
  end

  assign cp_we_o    = vld_q[DEPTH-1] & dok_q[DEPTH-1] & ~stall_i;
  assign cp_waddr_o = addr_q[DEPTH-1];
  assign cp_wdata_o = data_q[DEPTH-1];

  // Index NUM_RD is the EPC tap; the others are the read ports.
  logic [NUM_RD:0]             lk_hit, lk_pend;
  logic [NUM_RD:0][ADDR_W-1:0] lk_addr;
  logic [NUM_RD:0][DATA_W-1:0] lk_data;

  for (genvar p = 0; p <= NUM_RD; p++) begin : g_lookup
    if (p < NUM_RD) begin : g_port
      assign lk_addr[p] = rd_addr_i[p*ADDR_W +: ADDR_W];
      assign rd_data_o[p*DATA_W +: DATA_W] = (lk_hit[p] & ~lk_pend[p]) ? lk_data[p]
                                                                         : rd_arr_i[p*DATA_W +: DATA_W];
      assign rd_stall_o[p] = lk_hit[p] & lk_pend[p];
    end else begin : g_epc
      assign lk_addr[p] = EPC_ADDR;
    end

    cp0_fwd_lookup #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .LATE_STAGE (LATE_STAGE)
    ) u_lookup (
      .addr_i      (lk_addr[p]),
      .vld_i       (vld_q),
      .addr_vec_i  (addr_q),
      .data_vec_i  (data_q),
      .dok_i       (dok_q),
      .late_en_i   (late_en_i),
      .late_data_i (late_data_i),
      .hit_o       (lk_hit[p]),
      .pending_o   (lk_pend[p]),
      .data_o      (lk_data[p])
    );
  end

  assign epc_o = (lk_hit[NUM_RD] & ~lk_pend[NUM_RD]) ? lk_data[NUM_RD] : epc_arr_i;

endmodule

// File: tb/tb_cp0_fwd_pipe.sv
// Directed bench for cp0_fwd_pipe with a commit scoreboard.
module tb_cp0_fwd_pipe;
  import cp0_fwd_pipe_pkg::*;

  localparam logic [31:0] ARR0    = 32'hAAAA_0000;
  localparam logic [31:0] ARR1    = 32'h5555_0001;
  localparam logic [31:0] EPC_ARR = 32'hE0E0_E0E0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, iss_en, iss_dok, late_en;
  logic [4:0]  iss_addr, rd_a0, rd_a1;
  logic [31:0] iss_data, late_data;
  logic [63:0] rd_data;
  logic [1:0]  rd_stall;
  logic [31:0] epc, cp_wdata;
  logic        cp_we;
  logic [4:0]  cp_waddr;

  logic [36:0] sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  cp0_fwd_pipe u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall),
    .flush_i     (flush),
    .iss_en_i    (iss_en),
    .iss_addr_i  (iss_addr),
    .iss_data_i  (iss_data),
    .iss_dok_i   (iss_dok),
    .late_en_i   (late_en),
    .late_data_i (late_data),
    .rd_addr_i   ({rd_a1, rd_a0}),
    .rd_arr_i    ({ARR1, ARR0}),
    .epc_arr_i   (EPC_ARR),
    .rd_data_o   (rd_data),
    .rd_stall_o  (rd_stall),
    .epc_o       (epc),
    .cp_we_o     (cp_we),
    .cp_waddr_o  (cp_waddr),
    .cp_wdata_o  (cp_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic [31:0] d, input logic ok);
    iss_en   = 1'b1;
    iss_addr = a;
    iss_data = d;
    iss_dok  = ok;
  endtask

  // Commit scoreboard and pending-at-commit protocol monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      check("no_pend_at_commit", {31'b0, u_dut.vld_q[2] & ~u_dut.dok_q[2]}, 32'd0);
      if (cp_we) begin
        if (sb_q.size() == 0) begin
          check("commit_unexpected", 32'd1, 32'd0);
        end else begin
          logic [36:0] e;
          e = sb_q.pop_front();
          check("commit_addr", {27'b0, cp_waddr}, {27'b0, e[36:32]});
          check("commit_data", cp_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; iss_en = 1'b0; iss_dok = 1'b0; late_en = 1'b0;
    iss_addr = '0; iss_data = '0; late_data = '0; rd_a0 = CP0_STATUS; rd_a1 = CP0_STATUS;
    @(negedge clk);
    check("rst_we", {31'b0, cp_we}, 32'd0);
    check("rst_stall", {30'b0, rd_stall}, 32'd0);
    check("rst_rd0", rd_data[31:0], ARR0);
    check("rst_epc", epc, EPC_ARR);
    step();
    rst_n = 1'b1;
    step();

    // Basic forward then commit after DEPTH cycles.
    issue(CP0_STATUS, 32'h1, 1'b1); sb_q.push_back({CP0_STATUS, 32'h1});
    @(negedge clk); check("t1_c0_nofwd", rd_data[31:0], ARR0);
    step(); iss_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t1_rd0", rd_data[31:0], 32'h1);
      check("t1_rd1", rd_data[63:32], 32'h1);
      check("t1_we", {31'b0, cp_we}, (c == 3) ? 32'd1 : 32'd0);
      step();
    end
    @(negedge clk); check("t1_after", rd_data[31:0], ARR0);

    // Back-to-back EPC writes: youngest wins.
    step(); issue(CP0_EPC, 32'hBFC0_0100, 1'b1); sb_q.push_back({CP0_EPC, 32'hBFC0_0100});
    step(); issue(CP0_EPC, 32'hBFC0_0200, 1'b1); sb_q.push_back({CP0_EPC, 32'hBFC0_0200});
    @(negedge clk); check("t2_first", epc, 32'hBFC0_0100);
    step(); iss_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); check("t2_young", epc, 32'hBFC0_0200);
      step();
    end
    @(negedge clk); check("t2_drained", epc, EPC_ARR);

    // Pending data with late fill and same-cycle bypass.
    step(); issue(CP0_CAUSE, 32'hDEAD_BEEF, 1'b0); sb_q.push_back({CP0_CAUSE, 32'hA5});
    rd_a0 = CP0_CAUSE;
    step(); iss_en = 1'b0;
    @(negedge clk);
    check("t3_stall_s0", {31'b0, rd_stall[0]}, 32'd1);
    check("t3_nostall_p1", {31'b0, rd_stall[1]}, 32'd0);
    step();
    @(negedge clk); check("t3_stall_s1", {31'b0, rd_stall[0]}, 32'd1);
    late_en = 1'b1; late_data = 32'hA5;
    #1;
    check("t3_bypass_stall", {31'b0, rd_stall[0]}, 32'd0);
    check("t3_bypass_data", rd_data[31:0], 32'hA5);
    step(); late_en = 1'b0; late_data = 32'h0;
    @(negedge clk);
    check("t3_filled", rd_data[31:0], 32'hA5);
    check("t3_we", {31'b0, cp_we}, 32'd1);
    step(); late_en = 1'b1; late_data = 32'h77;
    step(); late_en = 1'b0;
    @(negedge clk); check("t3_late_ignored", rd_data[31:0], ARR0);

    // Flush kills younger entries; commit stage still commits.
    rd_a0 = CP0_STATUS;
    step(); issue(CP0_STATUS, 32'h11, 1'b1); sb_q.push_back({CP0_STATUS, 32'h11});
    step(); issue(CP0_STATUS, 32'h22, 1'b1);
    step(); iss_en = 1'b0;
    step(); flush = 1'b1; issue(CP0_STATUS, 32'h33, 1'b1);
    @(negedge clk);
    check("t4_flush_rd", rd_data[31:0], 32'h22);
    check("t4_flush_we", {31'b0, cp_we}, 32'd1);
    step(); flush = 1'b0; iss_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_post_rd", rd_data[31:0], ARR0);
      check("t4_post_we", {31'b0, cp_we}, 32'd0);
      step();
    end

    // Stall holds the commit stage.
    rd_a1 = 5'd15;
    issue(5'd15, 32'h77, 1'b1); sb_q.push_back({5'd15, 32'h77});
    step(); iss_en = 1'b0;
    step();
    step(); stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_stall_we", {31'b0, cp_we}, 32'd0);
      check("t5_stall_rd", rd_data[63:32], 32'h77);
      step();
    end
    stall = 1'b0;
    @(negedge clk); check("t5_release_we", {31'b0, cp_we}, 32'd1);
    step();
    @(negedge clk); check("t5_once", {31'b0, cp_we}, 32'd0);

    // Asynchronous reset mid-flight.
    step(); issue(CP0_STATUS, 32'h99, 1'b1); rd_a1 = CP0_CAUSE;
    step(); issue(CP0_CAUSE, 32'h0, 1'b0);
    step(); iss_en = 1'b0;
    @(negedge clk);
    check("t6_pre_rd", rd_data[31:0], 32'h99);
    check("t6_pre_stall", {31'b0, rd_stall[1]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd", rd_data[31:0], ARR0);
    check("t6_rst_stall", {30'b0, rd_stall}, 32'd0);
    check("t6_rst_we", {31'b0, cp_we}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); check("t6_no_commit", {31'b0, cp_we}, 32'd0);
      step();
    end

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
